// File: rtl/acorn_step_engine.sv
// -----------------------------------------------------------------------------
// acorn_step_engine
//
// ACORN-128 state-update core. It holds the 293-bit cipher state and, for each
// accepted beat, advances it STEPS rounds in one clock. Every round applies the
// six linear-feedback XORs, then derives the keystream bit (KSG128) and the
// feedback bit (FBK128 with ca/cb control), and shifts in f ^ message bit.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   load, load_state  overwrite the state with load_state (bit i = S[i])
//   in_valid/in_ready input handshake for din/ca/cb/dec (bit 0 = first round)
//   dec               1: message bit = din ^ ks (decrypt), 0: message bit = din
//   out_valid/out_ready output handshake for dout/ks
//   dout, ks          per-round din ^ ks and keystream, bit 0 = first round
//   state_out         current state register (tag extraction)
//
// STEPS must be one of 1, 2, 4, 8, 16, 32.
// -----------------------------------------------------------------------------
module acorn_step_engine #(
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [292:0]     load_state,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [STEPS-1:0] din,
    input  logic [STEPS-1:0] ca,
    input  logic [STEPS-1:0] cb,
    input  logic             dec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [STEPS-1:0] dout,
    output logic [STEPS-1:0] ks,
    output logic [292:0]     state_out
);

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    logic [292:0]     state_reg;
    logic             out_valid_reg;
    logic [STEPS-1:0] dout_reg;
    logic [STEPS-1:0] ks_reg;

    logic             fire;

    // stage_state[r] is the state entering round r; stage_state[STEPS] is the
    // state written back when a beat fires.
    logic [STEPS:0][292:0] stage_state;
    logic [STEPS-1:0]      ks_next;
    logic [STEPS-1:0]      dout_next;

    assign stage_state[0] = state_reg;

    for (genvar gi = 0; gi < STEPS; gi++) begin : g_round
        logic [292:0] s_pre;
        logic [292:0] s_mix;
        logic         ks_bit;
        logic         fb_bit;
        logic         msg_bit;

        assign s_pre = stage_state[gi];

        // The six linear updates only ever read taps that are updated later in
        // the sequence (or not at all), so every XOR reads the round's input.
        always_comb begin
            s_mix      = s_pre;
            s_mix[289] = s_pre[289] ^ s_pre[235] ^ s_pre[230];
            s_mix[230] = s_pre[230] ^ s_pre[196] ^ s_pre[193];
            s_mix[193] = s_pre[193] ^ s_pre[160] ^ s_pre[154];
            s_mix[154] = s_pre[154] ^ s_pre[111] ^ s_pre[107];
            s_mix[107] = s_pre[107] ^ s_pre[66]  ^ s_pre[61];
            s_mix[61]  = s_pre[61]  ^ s_pre[23]  ^ s_pre[0];
        end

        assign ks_bit = s_mix[12] ^ s_mix[154]
                      ^ maj(s_mix[235], s_mix[61], s_mix[193])
                      ^ ch(s_mix[230], s_mix[111], s_mix[66]);

        assign fb_bit = s_mix[0] ^ ~s_mix[107]
                      ^ maj(s_mix[244], s_mix[23], s_mix[160])
                      ^ (ca[gi] & s_mix[196])
                      ^ (cb[gi] & ks_bit);

        assign msg_bit = dec ? (din[gi] ^ ks_bit) : din[gi];

        assign ks_next[gi]   = ks_bit;
        assign dout_next[gi] = din[gi] ^ ks_bit;

        assign stage_state[gi+1] = {fb_bit ^ msg_bit, s_mix[292:1]};
    end

    // A load cycle never accepts a beat; the held beat goes in afterwards.
    assign in_ready = ~load & (~out_valid_reg | out_ready);
    assign fire     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= '0;
        end else if (load) begin
            state_reg <= load_state;
        end else if (fire) begin
            state_reg <= stage_state[STEPS];
        end
    end

    // Output slot: filled on fire, emptied when drained without a refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
            ks_reg        <= '0;
        end else if (fire) begin
            out_valid_reg <= 1'b1;
            dout_reg      <= dout_next;
            ks_reg        <= ks_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign dout      = dout_reg;
    assign ks        = ks_reg;
    assign state_out = state_reg;

endmodule

// File: tb/tb_acorn_step_engine.sv
// -----------------------------------------------------------------------------
// tb_acorn_step_engine
//
// Two engines: STEPS=1 for directed cases (single rounds, backpressure, reset
// mid-stream) and STEPS=4 against a bit-serial reference model over random
// beats with random backpressure and occasional reloads. Expected ks/dout
// values are queued when a beat is accepted and compared when it drains.
// Inputs change 1 time unit after the rising edge; outputs are read on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_acorn_step_engine;

    typedef struct {
        logic [3:0] ks;
        logic [3:0] dout;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // STEPS = 1 engine
    logic         load1;
    logic [292:0] ls1;
    logic         iv1;
    logic         ir1;
    logic [0:0]   din1, ca1, cb1;
    logic         dec1;
    logic         ov1;
    logic         or1;
    logic [0:0]   dout1, ks1;
    logic [292:0] so1;

    // STEPS = 4 engine
    logic         load4;
    logic [292:0] ls4;
    logic         iv4;
    logic         ir4;
    logic [3:0]   din4, ca4, cb4;
    logic         dec4;
    logic         ov4;
    logic         or4;
    logic [3:0]   dout4, ks4;
    logic [292:0] so4;

    int total_cnt = 0;
    int bad_cnt   = 0;

    exp_t q1[$];
    exp_t q4[$];

    acorn_step_engine #(.STEPS(1)) u_dut1 (
        .clk(clk), .rst(rst), .load(load1), .load_state(ls1),
        .in_valid(iv1), .in_ready(ir1), .din(din1), .ca(ca1), .cb(cb1),
        .dec(dec1), .out_valid(ov1), .out_ready(or1), .dout(dout1),
        .ks(ks1), .state_out(so1)
    );

    acorn_step_engine #(.STEPS(4)) u_dut4 (
        .clk(clk), .rst(rst), .load(load4), .load_state(ls4),
        .in_valid(iv4), .in_ready(ir4), .din(din4), .ca(ca4), .cb(cb4),
        .dec(dec4), .out_valid(ov4), .out_ready(or4), .dout(dout4),
        .ks(ks4), .state_out(so4)
    );

    task automatic check(input string tag, input logic [292:0] got,
                         input logic [292:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One ACORN round written straight from the round description, updating a
    // working copy in the listed order.
    task automatic ref_round(input logic [292:0] s_in, input logic d,
                             input logic a, input logic b, input logic dm,
                             output logic [292:0] s_out, output logic k);
        logic [292:0] s;
        logic f, m, mj_k, ch_k, mj_f;
        s = s_in;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66]  ^ s[61];
        s[61]  = s[61]  ^ s[23]  ^ s[0];
        mj_k = (s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193]);
        ch_k = (s[230] & s[111]) ^ ((~s[230]) & s[66]);
        k    = s[12] ^ s[154] ^ mj_k ^ ch_k;
        mj_f = (s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160]);
        f    = s[0] ^ (~s[107]) ^ mj_f ^ (a & s[196]) ^ (b & k);
        m    = dm ? (d ^ k) : d;
        for (int j = 0; j < 292; j++) s[j] = s[j+1];
        s[292] = f ^ m;
        s_out = s;
    endtask

    task automatic rand_state(output logic [292:0] v);
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
        v = t[292:0];
    endtask

    task automatic pop1(input string tag);
        exp_t e;
        check({tag, "_qhas"}, 293'(q1.size() > 0), 293'(1));
        if (q1.size() > 0) begin
            e = q1.pop_front();
            $display("tx dut1 %s ks=%0b dout=%0b", e.tag, ks1, dout1);
            check({tag, "_ks"},   293'(ks1),   293'(e.ks[0]));
            check({tag, "_dout"}, 293'(dout1), 293'(e.dout[0]));
        end
    endtask

    // Load st, then push one STEPS=1 beat and check it and the new state.
    task automatic beat1(input string tag, input logic [292:0] st,
                         input logic d, input logic a, input logic b,
                         input logic dm, input logic ek, input logic ed,
                         input logic [292:0] es);
        exp_t e;
        load1 = 1'b1; ls1 = st; iv1 = 1'b1; or1 = 1'b1;
        din1 = d; ca1 = a; cb1 = b; dec1 = dm;
        @(negedge clk);
        check({tag, "_rdy_load"}, 293'(ir1), 293'(0));
        @(posedge clk); #1;
        load1 = 1'b0;
        @(negedge clk);
        check({tag, "_rdy"}, 293'(ir1), 293'(1));
        e.ks = {3'b0, ek}; e.dout = {3'b0, ed}; e.tag = tag;
        if (iv1 && ir1) q1.push_back(e);
        @(posedge clk); #1;
        iv1 = 1'b0;
        @(negedge clk);
        check({tag, "_ov"}, 293'(ov1), 293'(1));
        pop1(tag);
        check({tag, "_state"}, so1, es);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [292:0] model, s_nx, st_bp, tmp;
        logic [3:0]   ek, ed;
        logic         kb;
        exp_t         e;
        int           fired, cyc;
        logic         took;

        rst = 1'b1;
        load1 = 1'b1; iv1 = 1'b0; din1 = '0; ca1 = '0; cb1 = '0; dec1 = 1'b0; or1 = 1'b0;
        load4 = 1'b0; iv4 = 1'b0; din4 = '0; ca4 = '0; cb4 = '0; dec4 = 1'b0; or4 = 1'b0;
        rand_state(tmp);
        ls1 = tmp; ls4 = '0;

        // ---------------- reset (load held high: reset must win)
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; load1 = 1'b0;
        @(negedge clk);
        check("rst_state", so1, '0);
        check("rst_ov",    293'(ov1), 293'(0));
        check("rst_dout",  293'(dout1), 293'(0));
        check("rst_ks",    293'(ks1), 293'(0));
        check("rst_rdy",   293'(ir1), 293'(1));
        check("rst_state4", so4, '0);
        @(posedge clk); #1;

        // ---------------- directed single rounds
        beat1("zero",   '0,             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              293'(1) << 292);
        beat1("s0",     293'(1),        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              293'(1) << 60);
        beat1("s12enc", 293'(1) << 12,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
              (293'(1) << 11) | (293'(1) << 292));
        beat1("s12dec", 293'(1) << 12,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
              293'(1) << 11);

        // ---------------- backpressure
        load1 = 1'b1; ls1 = '0;
        @(posedge clk); #1;
        load1 = 1'b0;
        iv1 = 1'b1; din1 = 1'b0; ca1 = 1'b0; cb1 = 1'b0; dec1 = 1'b0; or1 = 1'b0;
        @(negedge clk);
        check("bp_rdy0", 293'(ir1), 293'(1));
        e.ks = 4'd0; e.dout = 4'd0; e.tag = "bp1";
        if (iv1 && ir1) q1.push_back(e);
        @(posedge clk); #1;
        din1 = 1'b1;  // second beat, held while stalled
        st_bp = 293'(1) << 292;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rdy",   293'(ir1), 293'(0));
            check("bp_ov",    293'(ov1), 293'(1));
            check("bp_state", so1, st_bp);
            check("bp_dout",  293'(dout1), 293'(0));
            @(posedge clk); #1;
        end
        or1 = 1'b1;
        @(negedge clk);
        check("bp_rdy_rel", 293'(ir1), 293'(1));
        if (ov1 && or1) pop1("bp1");
        e.ks = 4'd0; e.dout = 4'd1; e.tag = "bp2";
        if (iv1 && ir1) q1.push_back(e);
        @(posedge clk); #1;
        iv1 = 1'b0; or1 = 1'b0;
        @(negedge clk);
        check("bp2_ov",    293'(ov1), 293'(1));
        check("bp2_dout",  293'(dout1), 293'(1));
        check("bp2_state", so1, 293'(1) << 291);

        // ---------------- reset mid-stream with pending output and load
        @(posedge clk); #1;
        rst = 1'b1; load1 = 1'b1; rand_state(tmp); ls1 = tmp; iv1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load1 = 1'b0; iv1 = 1'b0;
        @(negedge clk);
        check("mrst_state", so1, '0);
        check("mrst_ov",    293'(ov1), 293'(0));
        check("mrst_dout",  293'(dout1), 293'(0));
        check("mrst_ks",    293'(ks1), 293'(0));
        q1.delete();
        @(posedge clk); #1;

        // ---------------- STEPS=4 random run against the reference model
        load4 = 1'b1; rand_state(tmp); ls4 = tmp;
        @(negedge clk);
        model = ls4;
        @(posedge clk); #1;
        load4 = 1'b0;
        iv4 = 1'b1; din4 = 4'($urandom); ca4 = 4'($urandom); cb4 = 4'($urandom);
        dec4 = 1'($urandom); or4 = 1'b1;
        fired = 0; cyc = 0;
        while (fired < 1000 && cyc < 20000) begin
            @(negedge clk);
            check("r4_state", so4, model);
            if (ov4 && or4) begin
                check("r4_qhas", 293'(q4.size() > 0), 293'(1));
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    $display("tx dut4 %s ks=%h dout=%h", e.tag, ks4, dout4);
                    check("r4_ks",   293'(ks4),   293'(e.ks));
                    check("r4_dout", 293'(dout4), 293'(e.dout));
                end
            end
            took = 1'b0;
            if (load4) begin
                model = ls4;
            end else if (iv4 && ir4) begin
                s_nx = model;
                for (int r = 0; r < 4; r++) begin
                    ref_round(s_nx, din4[r], ca4[r], cb4[r], dec4, s_nx, kb);
                    ek[r] = kb;
                    ed[r] = din4[r] ^ kb;
                end
                model = s_nx;
                e.ks = ek; e.dout = ed; e.tag = $sformatf("b%0d", fired);
                q4.push_back(e);
                fired++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            // an un-accepted beat stays on the bus unchanged
            if (took || !iv4) begin
                iv4  = ($urandom_range(0, 3) != 0);
                din4 = 4'($urandom); ca4 = 4'($urandom); cb4 = 4'($urandom);
                dec4 = 1'($urandom);
            end
            load4 = ($urandom_range(0, 63) == 0);
            if (load4) begin
                rand_state(tmp);
                ls4 = tmp;
            end
            or4 = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("r4_beats", 293'(fired), 293'(1000));

        iv4 = 1'b0; load4 = 1'b0; or4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ov4 && or4 && q4.size() > 0) begin
                e = q4.pop_front();
                $display("tx dut4 %s ks=%h dout=%h", e.tag, ks4, dout4);
                check("r4_ks",   293'(ks4),   293'(e.ks));
                check("r4_dout", 293'(dout4), 293'(e.dout));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("r4_drained", 293'(q4.size()), 293'(0));
        check("r4_ov_end",  293'(ov4), 293'(0));
        check("r4_state_end", so4, model);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
